// File: rtl/flow_table_if.sv
// Bundles the flow_table lookup, result, CSR-read and drop-count signals.
// The table side uses the slave modport; the key source / CSR side uses master.
interface flow_table_if #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
);
   localparam int IW = $clog2(DEPTH);

   logic [95:0]      flow_key;
   logic             key_valid;
   logic             clr;
   logic             done;
   logic             hit;
   logic             miss_ins;
   logic             collision;
   logic [IW-1:0]    flow_idx;
   logic             rd_en;
   logic [IW-1:0]    rd_idx;
   logic             rd_valid;
   logic [95:0]      rd_key;
   logic [CNT_W-1:0] rd_count;
   logic             rd_used;
   logic [CNT_W-1:0] drop_cnt;

   modport master (
      output flow_key, key_valid, clr, rd_en, rd_idx,
      input  done, hit, miss_ins, collision, flow_idx,
      input  rd_valid, rd_key, rd_count, rd_used, drop_cnt
   );

   modport slave (
      input  flow_key, key_valid, clr, rd_en, rd_idx,
      output done, hit, miss_ins, collision, flow_idx,
      output rd_valid, rd_key, rd_count, rd_used, drop_cnt
   );
endinterface

// File: rtl/flow_table.sv
// Direct-mapped flow table: XOR-folded index, 3-cycle lookup/insert/count FSM.
// Define FLOW_TABLE_DROP_CNT_EN to build the saturating busy-drop counter.
module flow_table #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input logic          clk,
   input logic          rst_n,
   flow_table_if.slave  bus
);
   localparam int IW   = $clog2(DEPTH);
   localparam int NS   = (96 + IW - 1) / IW;
   localparam int PADW = NS * IW;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} state_t;

   state_t           r_state, w_next;
   logic [IW-1:0]    w_idx, r_idx;
   logic [PADW-1:0]  w_pad;
   logic [95:0]      r_key;
   logic [DEPTH-1:0] r_used;
   logic [95:0]      r_tkey [DEPTH];
   logic [CNT_W-1:0] r_tcnt [DEPTH];
   logic             r_e_used;
   logic [95:0]      r_e_key;
   logic [CNT_W-1:0] r_e_cnt, w_cnt_inc;
   logic             w_accept, w_wr, w_match;
   logic             r_done, r_hit, r_miss, r_coll;
   logic [IW-1:0]    r_flow_idx;
   logic             r_rd_valid, r_rd_used;
   logic [95:0]      r_rd_key;
   logic [CNT_W-1:0] r_rd_count;

   // Upper slice zero-padded by the widening cast
   always_comb begin
      w_pad = PADW'(bus.flow_key);
      w_idx = '0;
      for (int i = 0; i < NS; i++) w_idx ^= w_pad[i*IW +: IW];
   end

   assign w_accept  = (r_state == IDLE) && bus.key_valid && !bus.clr;
   assign w_wr      = (r_state == WRITE) && !bus.clr;
   assign w_match   = r_e_used && (r_e_key == r_key);
   assign w_cnt_inc = (r_e_cnt == '1) ? r_e_cnt : r_e_cnt + CNT_W'(1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = LOOKUP;
         LOOKUP:  w_next = WRITE;
         WRITE:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (bus.clr) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_used     <= '0;
         r_done     <= 1'b0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_coll     <= 1'b0;
         r_flow_idx <= '0;
         r_rd_valid <= 1'b0;
         r_rd_key   <= '0;
         r_rd_count <= '0;
         r_rd_used  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_wr;
         r_hit   <= w_wr && w_match;
         r_miss  <= w_wr && !r_e_used;
         r_coll  <= w_wr && r_e_used && !w_match;
         if (w_wr) r_flow_idx <= r_idx;
         if (bus.clr) r_used <= '0;
         else if (w_wr && !r_e_used) r_used[r_idx] <= 1'b1;
         // Reads sample storage before this edge's write/clear lands
         r_rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            r_rd_key   <= r_tkey[bus.rd_idx];
            r_rd_count <= r_tcnt[bus.rd_idx];
            r_rd_used  <= r_used[bus.rd_idx];
         end
      end
   end

   // Key/count storage and lookup pipeline need no reset: used=0 masks them
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_key <= bus.flow_key;
         r_idx <= w_idx;
      end
      if (r_state == LOOKUP) begin
         r_e_used <= r_used[r_idx];
         r_e_key  <= r_tkey[r_idx];
         r_e_cnt  <= r_tcnt[r_idx];
      end
      if (w_wr) begin
         if (!r_e_used) begin
            r_tkey[r_idx] <= r_key;
            r_tcnt[r_idx] <= CNT_W'(1);
         end else if (w_match) begin
            r_tcnt[r_idx] <= w_cnt_inc;
         end
      end
   end

`ifdef FLOW_TABLE_DROP_CNT_EN
   logic [CNT_W-1:0] r_drop;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_drop <= '0;
      else if ((r_state != IDLE) && bus.key_valid && !bus.clr && (r_drop != '1))
         r_drop <= r_drop + CNT_W'(1);
   end
   assign bus.drop_cnt = r_drop;
`else
   assign bus.drop_cnt = '0;
`endif

   assign bus.done      = r_done;
   assign bus.hit       = r_hit;
   assign bus.miss_ins  = r_miss;
   assign bus.collision = r_coll;
   assign bus.flow_idx  = r_flow_idx;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_key    = r_rd_key;
   assign bus.rd_count  = r_rd_count;
   assign bus.rd_used   = r_rd_used;
endmodule

// File: tb/tb_flow_table.sv
// Directed bench for flow_table (DEPTH=16, CNT_W=4 so saturation is reachable).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_flow_table;
   localparam int DEPTH = 16;
   localparam int CNT_W = 4;
`ifdef FLOW_TABLE_DROP_CNT_EN
   localparam bit DROP_ON = 1'b1;
`else
   localparam bit DROP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   flow_table_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
   flow_table #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [95:0] k, input logic h, input logic m, input logic c,
                       input logic [3:0] idx, input string tag);
      bus.flow_key  = k;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      chk({tag, ".done+1"}, bus.done, 0);
      @(negedge clk);
      chk({tag, ".done+2"}, bus.done, 0);
      @(negedge clk);
      chk({tag, ".done"}, bus.done, 1);
      chk({tag, ".hit"}, bus.hit, h);
      chk({tag, ".miss"}, bus.miss_ins, m);
      chk({tag, ".coll"}, bus.collision, c);
      chk({tag, ".idx"}, bus.flow_idx, idx);
   endtask

   task automatic rd(input logic [3:0] idx, input logic used, input logic [95:0] key,
                     input logic [3:0] cnt, input string tag);
      bus.rd_en  = 1'b1;
      bus.rd_idx = idx;
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk({tag, ".rd_valid"}, bus.rd_valid, 1);
      chk({tag, ".rd_used"}, bus.rd_used, used);
      if (used) begin
         chk({tag, ".rd_key"}, bus.rd_key, key);
         chk({tag, ".rd_count"}, bus.rd_count, cnt);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flow_key = '0; bus.key_valid = 1'b0; bus.clr = 1'b0;
      bus.rd_en = 1'b0; bus.rd_idx = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.done", bus.done, 0);
      chk("rst.flags", {bus.hit, bus.miss_ins, bus.collision}, 0);
      chk("rst.flow_idx", bus.flow_idx, 0);
      chk("rst.rd_valid", bus.rd_valid, 0);
      chk("rst.drop_cnt", bus.drop_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // First insert, then four hits issued back-to-back on each done cycle
      send(96'h1, 0, 1, 0, 4'd1, "ins1");
      rd(4'd1, 1, 96'h1, 4'd1, "rd_ins1");
      for (int i = 0; i < 4; i++) send(96'h1, 1, 0, 0, 4'd1, "hit1");
      rd(4'd1, 1, 96'h1, 4'd5, "rd_hit1");

      // 96'h10 folds to index 1 as well
      send(96'h10, 0, 0, 1, 4'd1, "coll");
      rd(4'd1, 1, 96'h1, 4'd5, "rd_coll");
      send(96'h5, 0, 1, 0, 4'd5, "ins5");
      send(96'hF00000000000000000000003, 0, 1, 0, 4'd12, "ins12");

      // Two consecutive keys: second dropped; read in WRITE cycle sees pre-write count
      bus.flow_key = 96'h5; bus.key_valid = 1'b1;
      @(negedge clk);
      bus.flow_key = 96'h77;
      @(negedge clk);
      bus.key_valid = 1'b0; bus.rd_en = 1'b1; bus.rd_idx = 4'd5;
      chk("drop.done+2", bus.done, 0);
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk("drop.done", bus.done, 1);
      chk("drop.hit", bus.hit, 1);
      chk("drop.idx", bus.flow_idx, 5);
      chk("drop.rd_valid", bus.rd_valid, 1);
      chk("drop.rd_prewrite", bus.rd_count, 1);
      chk("drop.drop_cnt", bus.drop_cnt, DROP_ON ? 1 : 0);
      rd(4'd5, 1, 96'h5, 4'd2, "rd_after_drop");
      rd(4'd0, 0, 96'h0, 4'd0, "rd_dropped_idx");

      // clr during LOOKUP aborts; same-cycle read returns pre-clear contents
      bus.flow_key = 96'hF00000000000000000000003; bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0; bus.clr = 1'b1; bus.rd_en = 1'b1; bus.rd_idx = 4'd1;
      @(negedge clk);
      bus.clr = 1'b0; bus.rd_en = 1'b0;
      chk("clr.done+2", bus.done, 0);
      chk("clr.rd_preclear", bus.rd_used, 1);
      @(negedge clk);
      chk("clr.done+3", bus.done, 0);
      @(negedge clk);
      chk("clr.done+4", bus.done, 0);
      rd(4'd1, 0, 96'h0, 4'd0, "clr.rd1");
      rd(4'd12, 0, 96'h0, 4'd0, "clr.rd12");
      send(96'h1, 0, 1, 0, 4'd1, "clr.reins");
      rd(4'd1, 1, 96'h1, 4'd1, "clr.rd_reins");

      // clr beats a simultaneous key: neither processed nor dropped
      bus.flow_key = 96'h5; bus.key_valid = 1'b1; bus.clr = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0; bus.clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("clrkey.done", bus.done, 0);
         @(negedge clk);
      end
      chk("clrkey.drop_cnt", bus.drop_cnt, DROP_ON ? 1 : 0);
      rd(4'd5, 0, 96'h0, 4'd0, "clrkey.rd5");
      send(96'h5, 0, 1, 0, 4'd5, "clrkey.ins5");

      // Reset mid-lookup: no done after release, table and drop_cnt cleared
      bus.flow_key = 96'h3; bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid.drop_cnt", bus.drop_cnt, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rstmid.done", bus.done, 0);
         @(negedge clk);
      end
      rd(4'd3, 0, 96'h0, 4'd0, "rstmid.rd3");
      rd(4'd5, 0, 96'h0, 4'd0, "rstmid.rd5");

      // Bring entry 2 to all-ones-1, then two more hits must stop at all-ones
      send(96'h2, 0, 1, 0, 4'd2, "sat.ins");
      for (int i = 0; i < 13; i++) send(96'h2, 1, 0, 0, 4'd2, "sat.pre");
      rd(4'd2, 1, 96'h2, 4'hE, "sat.rd14");
      send(96'h2, 1, 0, 0, 4'd2, "sat.hitA");
      send(96'h2, 1, 0, 0, 4'd2, "sat.hitB");
      rd(4'd2, 1, 96'h2, 4'hF, "sat.rd15");

      // Hold key_valid 30 cycles: 20 drops saturate the 4-bit drop counter
      bus.flow_key = 96'h2; bus.key_valid = 1'b1;
      repeat (30) @(negedge clk);
      bus.key_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("dropsat.drop_cnt", bus.drop_cnt, DROP_ON ? 4'hF : 4'h0);
      rd(4'd2, 1, 96'h2, 4'hF, "dropsat.rd2");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/flow_table.md
FLOW_TABLE -- requirements
Module: flow_table

Interface
REQ-001 Parameter DEPTH, default 16, number of table entries; SHALL be a power of two, 4..256.
REQ-002 Parameter CNT_W, default 32, width of the per-entry packet counter and the drop counter.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port flow_key, input, 96, {src_ip, dst_ip, src_port, dst_port} from the flow key generator.
REQ-006 Port key_valid, input, 1, one-cycle pulse qualifying flow_key; no backpressure.
REQ-007 Port clr, input, 1, one-cycle pulse invalidating all entries.
REQ-008 Port done, output, 1, one-cycle pulse when a lookup completes.
REQ-009 Port hit, miss_ins, collision, each output, 1, result flags, valid only while done=1.
REQ-010 Port flow_idx, output, $clog2(DEPTH), entry index of the completed lookup, valid while done=1.
REQ-011 Port rd_en, input, 1; rd_idx, input, $clog2(DEPTH): CSR-side read request.
REQ-012 Port rd_valid, output, 1; rd_key, output, 96; rd_count, output, CNT_W; rd_used, output, 1: read response.
REQ-013 Port drop_cnt, output, CNT_W, keys discarded because the block was busy.

Function
REQ-014 Index SHALL be the XOR fold of flow_key into $clog2(DEPTH)-bit slices, LSB slice first; the upper slice is zero-padded.
REQ-015 Each entry SHALL hold a used bit, the 96-bit key, and a CNT_W packet counter.
REQ-016 FSM states: IDLE, LOOKUP, WRITE. Reset state is IDLE.
REQ-017 IDLE: key_valid=1 SHALL capture flow_key and its index, then go to LOOKUP.
REQ-018 LOOKUP: SHALL register the entry at the index and go to WRITE.
REQ-019 WRITE: if used and key matches, count+1 (hit=1).
REQ-020 WRITE: if not used, store key, used=1, count=1 (miss_ins=1).
REQ-021 WRITE: if used and key differs, leave the entry unchanged (collision=1).
REQ-022 WRITE SHALL pulse done for exactly one cycle with exactly one flag set, then return to IDLE.
REQ-023 Latency: key_valid in cycle N gives done in cycle N+3; throughput is one key per 3 cycles.
REQ-024 key_valid in LOOKUP or WRITE SHALL discard the key and increment drop_cnt.
REQ-025 key_valid in IDLE in the cycle done is high SHALL be accepted.
REQ-026 Packet counter and drop_cnt SHALL saturate at all-ones and never wrap.
REQ-027 clr SHALL clear every used bit next cycle and force the FSM to IDLE; an in-flight lookup is aborted with no done and no table write.
REQ-028 clr takes priority over a simultaneous key_valid; that key is neither counted nor dropped.
REQ-029 Read: rd_en in cycle N gives rd_valid=1 in cycle N+1 with rd_key, rd_count, rd_used of entry rd_idx.
REQ-030 Read in the same cycle as a WRITE to the same entry SHALL return the pre-write value.
REQ-031 Read in the same cycle as clr SHALL return pre-clear contents.
REQ-032 drop_cnt SHALL NOT be cleared by clr.

Reset
REQ-033 rst_n low SHALL asynchronously clear FSM to IDLE, all used bits, done, hit, miss_ins, collision, flow_idx, rd_valid, rd_key, rd_count, rd_used, and drop_cnt to 0.
REQ-034 Key and count storage need not be reset; used=0 masks them.
REQ-035 Reset asserted mid-lookup SHALL abort it with no done pulse after release.

Configuration
REQ-036 Macro FLOW_TABLE_DROP_CNT_EN defined: drop_cnt logic per REQ-024/026/032 is present.
REQ-037 Macro undefined: drop_cnt is constant 0 and no counter register exists; dropped keys are still discarded silently.

Verification
REQ-038 Reset, then key 96'h1 pulse -> done at +3 cycles, miss_ins=1, flow_idx=1; read idx 1 -> rd_used=1, rd_key=96'h1, rd_count=1.
REQ-039 Same key 96'h1 sent 4 more times, 3 cycles apart -> 4 hits; rd_count=5.
REQ-040 Key 96'h1 then key 96'h10 (idx 1, DEPTH=16) -> second gives collision=1, flow_idx=1; entry keeps key 96'h1.
REQ-041 key_valid on two consecutive cycles -> one done, second discarded, drop_cnt=1 (macro on) or 0 (macro off).
REQ-042 clr in the LOOKUP cycle -> no done; read any index -> rd_used=0; next key gives miss_ins.
REQ-043 Preload count to CNT_W all-ones-1, send 2 hits -> rd_count=all-ones, no wrap.
